// File: rtl/i2s_tx_if.sv
// i2s_tx_if: stereo sample hand-off from the synthesis engine to the I2S
// transmitter.
//   left, right   : two's-complement channel samples
//   sample_valid  : producer has a stereo sample on left/right
//   sample_ready  : transmitter's one-entry pending buffer is empty
// master = sample producer, slave = i2s_tx.
interface i2s_tx_if #(
  parameter int unsigned WIDTH = 24
);
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output left,
    output right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left,
    input  right,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: I2S serial transmitter. Derives sclk from the divider's mclk level,
// frames on the divider's lrck level and shifts one stereo sample per frame
// MSB-first with the standard one-bit delay. A left frame with no pending
// sample is sent as silence and flagged on underrun.
//   clk, rst     : system clock, synchronous active-high reset
//   mclk, lrck   : divider clock levels (synchronous to clk)
//   smp          : sample hand-off (slave side, one-entry buffer)
//   sclk, sdata  : I2S bit clock and serial data
//   lrck_o       : lrck delayed one clk, aligned with sclk/sdata
//   underrun     : one-cycle pulse when a left frame starts empty
module i2s_tx #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned SCLK_HALF = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    mclk,
  input  logic    lrck,
  i2s_tx_if.slave smp,
  output logic    sclk,
  output logic    sdata,
  output logic    lrck_o,
  output logic    underrun
);
  localparam int unsigned CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);

  // lrck_o doubles as the registered lrck copy used for edge detection.
  logic             mclk_d;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [BIT_W-1:0] bits, bits_nxt;
  logic [WIDTH-1:0] shifter, shifter_nxt;
  logic [WIDTH-1:0] right_hold, right_hold_nxt;
  logic [WIDTH-1:0] pend_l, pend_l_nxt;
  logic [WIDTH-1:0] pend_r, pend_r_nxt;
  logic             full, full_nxt;
  logic             ready_q;
  logic             sclk_nxt, sdata_nxt, underrun_nxt;
  logic             mclk_rise_c, lrck_edge_c, left_edge_c, right_edge_c;
  logic             handshake_c, div_wrap_c;

  // Next-state logic: buffer, frame loads, sclk divider and bit shifting.
  always_comb begin
    mclk_rise_c    = mclk & ~mclk_d;
    lrck_edge_c    = lrck ^ lrck_o;
    left_edge_c    = lrck_edge_c & ~lrck;
    right_edge_c   = lrck_edge_c & lrck;
    handshake_c    = smp.sample_valid & ready_q;
    div_wrap_c     = mclk_rise_c && (cnt == CNT_W'(SCLK_HALF - 1));

    cnt_nxt        = cnt;
    bits_nxt       = bits;
    shifter_nxt    = shifter;
    right_hold_nxt = right_hold;
    pend_l_nxt     = pend_l;
    pend_r_nxt     = pend_r;
    full_nxt       = full;
    sclk_nxt       = sclk;
    sdata_nxt      = sdata;
    underrun_nxt   = 1'b0;

    // ready_q tracks ~full, so a handshake never meets a consuming left edge;
    // a handshake on an empty left edge lands in the buffer for the next frame.
    if (handshake_c) begin
      pend_l_nxt = smp.left;
      pend_r_nxt = smp.right;
      full_nxt   = 1'b1;
    end

    if (left_edge_c) begin
      if (full) begin
        shifter_nxt    = pend_l;
        right_hold_nxt = pend_r;
        full_nxt       = 1'b0;
      end else begin
        shifter_nxt    = '0;
        right_hold_nxt = '0;
        underrun_nxt   = 1'b1;
      end
    end else if (right_edge_c) begin
      shifter_nxt = right_hold;
    end

    // Frame edge restarts the bit clock phase and suppresses any divider toggle.
    if (lrck_edge_c) begin
      cnt_nxt   = '0;
      sclk_nxt  = 1'b0;
      sdata_nxt = 1'b0;
      bits_nxt  = '0;
    end else if (mclk_rise_c) begin
      if (div_wrap_c) begin
        cnt_nxt  = '0;
        sclk_nxt = ~sclk;
        // Data changes on sclk falling so it is stable at the DAC's rising sample.
        if (sclk) begin
          if (bits < BIT_W'(WIDTH)) begin
            sdata_nxt   = shifter[WIDTH-1];
            shifter_nxt = {shifter[WIDTH-2:0], 1'b0};
            bits_nxt    = bits + 1'b1;
          end else begin
            sdata_nxt = 1'b0;
          end
        end
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // State register; ready is held low while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_d     <= 1'b0;
      lrck_o     <= 1'b0;
      cnt        <= '0;
      bits       <= '0;
      shifter    <= '0;
      right_hold <= '0;
      pend_l     <= '0;
      pend_r     <= '0;
      full       <= 1'b0;
      ready_q    <= 1'b0;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      mclk_d     <= mclk;
      lrck_o     <= lrck;
      cnt        <= cnt_nxt;
      bits       <= bits_nxt;
      shifter    <= shifter_nxt;
      right_hold <= right_hold_nxt;
      pend_l     <= pend_l_nxt;
      pend_r     <= pend_r_nxt;
      full       <= full_nxt;
      ready_q    <= ~full_nxt;
      sclk       <= sclk_nxt;
      sdata      <= sdata_nxt;
      underrun   <= underrun_nxt;
    end
  end

  assign smp.sample_ready = ready_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed/randomised bench for i2s_tx. A free-running source
// models the clock divider; a monitor decodes the I2S stream at sclk rising
// edges into per-half-frame records, which are compared with frames predicted
// from the sample schedule.
module tb_i2s_tx;
  localparam int unsigned WIDTH     = 24;
  localparam int unsigned SCLK_HALF = 1;

  typedef struct {
    logic        lr;
    logic [63:0] bits;
    int          n;
    logic        ur;
  } frame_t;

  typedef struct {
    logic             lr;
    logic [WIDTH-1:0] s;
    int               h;
    logic             ur;
  } exp_t;

  logic clk, rst, mclk, lrck;
  logic sclk, sdata, lrck_o, underrun;

  i2s_tx_if #(.WIDTH(WIDTH)) smp ();

  i2s_tx #(.WIDTH(WIDTH), .SCLK_HALF(SCLK_HALF)) dut (
    .clk     (clk),
    .rst     (rst),
    .mclk    (mclk),
    .lrck    (lrck),
    .smp     (smp),
    .sclk    (sclk),
    .sdata   (sdata),
    .lrck_o  (lrck_o),
    .underrun(underrun)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  int     half_len = 32;  // lrck half-period in sclk periods
  int     exp_ur_total = 0;
  int     ur_pulses = 0;
  int     ur_long   = 0;
  frame_t frames[$];
  exp_t   exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divider model: mclk toggles every clk, lrck toggles every half_len sclk periods.
  initial begin
    int rise_cnt;
    mclk = 1'b0;
    lrck = 1'b0;
    rise_cnt = 0;
    forever begin
      @(negedge clk);
      mclk = ~mclk;
      if (mclk) begin
        rise_cnt++;
        if (rise_cnt >= half_len * 2 * int'(SCLK_HALF)) begin
          lrck = ~lrck;
          rise_cnt = 0;
        end
      end
    end
  end

  // I2S receiver: collect sdata at each sclk rise, close a record on lrck_o change.
  logic [63:0] cap_bits;
  int          cap_n;
  logic        cap_ur, prev_lro, prev_sclk, ur_prev;
  always @(negedge clk) begin
    if (rst) begin
      cap_bits  = '0;
      cap_n     = 0;
      cap_ur    = 1'b0;
      prev_lro  = lrck_o;
      prev_sclk = sclk;
      ur_prev   = 1'b0;
    end else begin
      if (underrun) begin
        ur_pulses++;
        if (ur_prev) ur_long++;
      end
      ur_prev = underrun;
      if (lrck_o !== prev_lro) begin
        frames.push_back('{lr: prev_lro, bits: cap_bits, n: cap_n, ur: cap_ur});
        cap_bits = '0;
        cap_n    = 0;
        cap_ur   = underrun;
      end else if (sclk && !prev_sclk) begin
        if (cap_n < 64) cap_bits[cap_n[5:0]] = sdata;
        cap_n++;
      end
      prev_lro  = lrck_o;
      prev_sclk = sclk;
    end
  end

  // Receiver view of a half frame: delay slot, MSB-first sample, zero padding.
  function automatic logic [63:0] exp_bits(input logic [WIDTH-1:0] s, input int h);
    logic [63:0] v;
    v = '0;
    for (int i = 1; i < h && i <= int'(WIDTH); i++) v[6'(i)] = s[5'(int'(WIDTH) - i)];
    return v;
  endfunction

  function automatic void push_exp(input logic lr, input logic [WIDTH-1:0] s,
                                   input int h, input logic ur);
    exp_q.push_back('{lr: lr, s: s, h: h, ur: ur});
    if (ur) exp_ur_total++;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frames(input int n);
    frame_t f;
    exp_t   e;
    int     t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (frames.size() == 0 && t < 4000) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk("frame_wait", 64'(frames.size() != 0), 64'd1);
      if (frames.size() == 0) begin
        exp_q.delete();
        return;
      end
      f = frames.pop_front();
      e = exp_q.pop_front();
      chk("frame_lr",   64'(f.lr), 64'(e.lr));
      chk("frame_len",  64'(f.n),  64'(e.h));
      chk("frame_bits", f.bits,    exp_bits(e.s, e.h));
      chk("frame_ur",   64'(f.ur), 64'(e.ur));
    end
  endtask

  // Wait for the start of a left half-frame and drop older records.
  task automatic sync_left();
    logic prev;
    bit   got;
    prev = lrck_o;
    got  = 1'b0;
    for (int t = 0; t < 4000 && !got; t++) begin
      @(posedge clk);
      #1;
      got  = (prev === 1'b1 && lrck_o === 1'b0);
      prev = lrck_o;
    end
    chk("sync_left_wait", 64'(got), 64'd1);
    @(negedge clk);
    #1;
    frames.delete();
  endtask

  task automatic push_sample(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                             input bit hold, output int waited, output bit edge_ok);
    logic prev;
    bit   done;
    smp.left         = l;
    smp.right        = r;
    smp.sample_valid = 1'b1;
    prev    = lrck_o;
    done    = 1'b0;
    edge_ok = 1'b0;
    waited  = 0;
    while (waited < 3000) begin
      if (smp.sample_ready === 1'b1) begin
        done    = 1'b1;
        edge_ok = (prev === 1'b1 && lrck_o === 1'b0);
        break;
      end
      prev = lrck_o;
      @(posedge clk);
      #1;
      waited++;
    end
    chk("accept_wait", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) smp.sample_valid = 1'b0;
    chk("ready_fall", 64'(smp.sample_ready), 64'd0);
  endtask

  initial begin
    int               w;
    bit               eok;
    logic             prev_l;
    bit               got;
    logic [WIDTH-1:0] al [3];
    logic [WIDTH-1:0] ar [3];
    logic [WIDTH-1:0] dl, dr;

    rst = 1'b1;
    smp.sample_valid = 1'b0;
    smp.left  = '0;
    smp.right = '0;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({sclk, sdata, lrck_o, underrun, smp.sample_ready}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 64'(smp.sample_ready), 64'd1);

    // First left edge after reset underruns; then the boundary-pattern sample.
    sync_left();
    push_exp(1'b0, '0, half_len, 1'b1);
    push_exp(1'b1, '0, half_len, 1'b0);
    push_sample(24'h800001, 24'h7FFFFE, 1'b0, w, eok);
    push_exp(1'b0, 24'h800001, half_len, 1'b0);
    push_exp(1'b1, 24'h7FFFFE, half_len, 1'b0);
    check_frames(4);

    // Underrun then recovery
    dr = WIDTH'($urandom);
    push_exp(1'b0, '0, half_len, 1'b1);
    push_exp(1'b1, '0, half_len, 1'b0);
    push_sample(24'h123456, dr, 1'b0, w, eok);
    push_exp(1'b0, 24'h123456, half_len, 1'b0);
    push_exp(1'b1, dr, half_len, 1'b0);
    check_frames(4);

    // Back-pressure with valid held across three random samples
    for (int i = 0; i < 3; i++) begin
      al[i] = WIDTH'($urandom);
      ar[i] = WIDTH'($urandom);
    end
    push_exp(1'b0, '0, half_len, 1'b1);
    push_exp(1'b1, '0, half_len, 1'b0);
    push_sample(al[0], ar[0], 1'b1, w, eok);
    for (int i = 1; i < 3; i++) begin
      push_sample(al[i], ar[i], i < 2, w, eok);
      chk("backpressure_held", 64'(w > 2), 64'd1);
      chk("ready_rise_on_left_edge", 64'(eok), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, al[i], half_len, 1'b0);
      push_exp(1'b1, ar[i], half_len, 1'b0);
    end
    check_frames(8);

    // Handshake coinciding with an empty left edge
    push_exp(1'b0, '0, half_len, 1'b1);
    push_exp(1'b1, '0, half_len, 1'b0);
    dl = WIDTH'($urandom);
    dr = WIDTH'($urandom);
    prev_l = lrck;
    got = 1'b0;
    for (int t = 0; t < 4000 && !got; t++) begin
      @(negedge clk);
      #1;
      got = (prev_l === 1'b1 && lrck === 1'b0);
      prev_l = lrck;
    end
    chk("coincident_wait", 64'(got), 64'd1);
    smp.left = dl;
    smp.right = dr;
    smp.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    smp.sample_valid = 1'b0;
    chk("coincident_underrun", 64'(underrun), 64'd1);
    chk("coincident_accepted", 64'(smp.sample_ready), 64'd0);
    push_exp(1'b0, '0, half_len, 1'b1);
    push_exp(1'b1, '0, half_len, 1'b0);
    push_exp(1'b0, dl, half_len, 1'b0);
    push_exp(1'b1, dr, half_len, 1'b0);
    check_frames(6);

    // Short frames drop LSBs; a following full frame restarts cleanly
    half_len = 10;
    dl = WIDTH'($urandom);
    dr = WIDTH'($urandom);
    push_exp(1'b0, '0, 10, 1'b1);
    push_exp(1'b1, '0, 10, 1'b0);
    push_sample(dl, dr, 1'b0, w, eok);
    push_exp(1'b0, dl, 10, 1'b0);
    push_exp(1'b1, dr, 10, 1'b0);
    check_frames(4);
    half_len = 32;
    dl = WIDTH'($urandom);
    dr = WIDTH'($urandom);
    push_exp(1'b0, '0, 32, 1'b1);
    push_exp(1'b1, '0, 32, 1'b0);
    push_sample(dl, dr, 1'b0, w, eok);
    push_exp(1'b0, dl, 32, 1'b0);
    push_exp(1'b1, dr, 32, 1'b0);
    check_frames(4);
    exp_ur_total++;  // the left frame now starting is empty

    // Reset mid-frame with a pending sample: it is discarded
    push_sample(WIDTH'($urandom), WIDTH'($urandom), 1'b0, w, eok);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_outputs", 64'({sclk, sdata, lrck_o, underrun, smp.sample_ready}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_held", 64'({sclk, sdata, lrck_o, underrun, smp.sample_ready}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_midreset", 64'(smp.sample_ready), 64'd1);
    sync_left();
    push_exp(1'b0, '0, half_len, 1'b1);
    check_frames(1);

    chk("underrun_width", 64'(ur_long), 64'd0);
    chk("underrun_count", 64'(ur_pulses), 64'(exp_ur_total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
